xor3_monitor: RTL

- Synthesizable, clocked checker directly downstream of the three-input XOR stage (res = a ^ b ^ c).
- Samples a, b, c and res once per clock over a programmed window and recomputes the expected parity.
- Counts mismatches, captures the first failing sample, and reports pass/fail with a done handshake.
- Lets the coroutine-driven bench, or silicon self-test, read a verdict instead of checking res itself.

---
 rtl/xor3_mon_pkg.sv | 17 +
 rtl/xor3_monitor_sat_counter.sv | 25 ++
 rtl/xor3_monitor.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/xor3_mon_pkg.sv
// Shared types and helpers for the xor3_monitor parity checker.
package xor3_mon_pkg;

  localparam int VEC_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SKIP = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic xor3_expect(input logic a, input logic b, input logic c);
    return a ^ b ^ c;
  endfunction

endpackage

// File: rtl/xor3_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/xor3_monitor.sv
// Windowed checker for a three-input XOR stage: counts parity mismatches and records the first.
// Optional coverage outputs (cov_mask, cov_full) are built when XOR3_MON_COVER_EN is defined.
module xor3_monitor
  import xor3_mon_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int SKIP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             res,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] sample_count,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [VEC_W-1:0] first_err_vec,
`ifdef XOR3_MON_COVER_EN
  output logic [7:0]       cov_mask,
  output logic             cov_full,
`endif
  output logic             first_err_vld
);

  localparam logic [3:0] SKIP_L = 4'(SKIP);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] limit_q, limit_d;
  logic [CNT_W-1:0] sample_q, sample_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic             vld_q, vld_d;
  logic [3:0]       skip_q, skip_d;
  logic [VEC_W-1:0] smp_q;
  logic             accept;
  logic             mismatch;

  assign accept   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign mismatch = (state_q == ST_RUN) &&
                    (xor3_expect(smp_q[3], smp_q[2], smp_q[1]) != smp_q[0]);

  // NOTE: every always_comb output is defaulted first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    limit_d  = limit_q;
    sample_d = sample_q;
    idx_d    = idx_q;
    vec_d    = vec_q;
    vld_d    = vld_q;
    skip_d   = skip_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          limit_d  = num_samples;
          sample_d = '0;
          idx_d    = '0;
          vec_d    = '0;
          vld_d    = 1'b0;
          skip_d   = SKIP_L;
          if (num_samples == '0)   state_d = ST_DONE;
          else if (SKIP_L == 4'd0) state_d = ST_RUN;
          else                     state_d = ST_SKIP;
        end
      end
      ST_SKIP: begin
        skip_d = skip_q - 4'd1;
        if (skip_q == 4'd1) state_d = ST_RUN;
      end
      ST_RUN: begin
        sample_d = sample_q + 1'b1;
        if (mismatch && !vld_q) begin
          idx_d = sample_q;
          vec_d = smp_q;
          vld_d = 1'b1;
        end
        if (sample_d == limit_q) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The pin sample register is reset too, so the first compare after reset never sees X.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      limit_q  <= '0;
      sample_q <= '0;
      idx_q    <= '0;
      vec_q    <= '0;
      vld_q    <= 1'b0;
      skip_q   <= '0;
      smp_q    <= '0;
    end else begin
      state_q  <= state_d;
      limit_q  <= limit_d;
      sample_q <= sample_d;
      idx_q    <= idx_d;
      vec_q    <= vec_d;
      vld_q    <= vld_d;
      skip_q   <= skip_d;
      smp_q    <= {a, b, c, res};
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_err_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (accept),
    .inc_i   (mismatch),
    .count_o (err_count)
  );

  assign busy          = (state_q == ST_SKIP) || (state_q == ST_RUN);
  assign done          = (state_q == ST_DONE);
  assign pass          = done && (err_count == '0);
  assign sample_count  = sample_q;
  assign first_err_idx = idx_q;
  assign first_err_vec = vec_q;
  assign first_err_vld = vld_q;

`ifdef XOR3_MON_COVER_EN
  logic [7:0] cov_mask_q, cov_mask_d;
  logic       cov_full_q;

  always_comb begin
    cov_mask_d = cov_mask_q;
    if (accept)                  cov_mask_d = '0;
    else if (state_q == ST_RUN)  cov_mask_d[smp_q[3:1]] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cov_mask_q <= '0;
      cov_full_q <= 1'b0;
    end else begin
      cov_mask_q <= cov_mask_d;
      cov_full_q <= &cov_mask_d;
    end
  end

  assign cov_mask = cov_mask_q;
  assign cov_full = cov_full_q;
`endif

endmodule
